// File: rtl/dmem_ctrl_pkg.sv
// Shared constants for the data-memory controller: access-size encodings,
// FSM state codes and the datapath width.
package dmem_ctrl_pkg;

  localparam int XLEN = 64;

  localparam logic [1:0] MASK_BYTE   = 2'b00;
  localparam logic [1:0] MASK_HALF   = 2'b01;
  localparam logic [1:0] MASK_WORD   = 2'b10;
  localparam logic [1:0] MASK_DOUBLE = 2'b11;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  // Byte-count mask for an access of 2^size bytes, lane 0.
  function automatic logic [7:0] size_mask(input logic [1:0] size);
    case (size)
      MASK_BYTE: size_mask = 8'h01;
      MASK_HALF: size_mask = 8'h03;
      MASK_WORD: size_mask = 8'h0F;
      default:   size_mask = 8'hFF;
    endcase
  endfunction

endpackage

// File: rtl/dmem_ctrl_lane_align.sv
// Lane steering for one 64-bit word: byte enables and shifted data for stores,
// extracted and sign/zero-extended data for loads.
module dmem_lane_align
  import dmem_ctrl_pkg::*;
(
  input  logic [2:0]      lane,
  input  logic [1:0]      size,
  input  logic            is_unsigned,
  input  logic [XLEN-1:0] word,
  input  logic [XLEN-1:0] wdata,
  output logic [7:0]      byte_en,
  output logic [XLEN-1:0] wdata_shifted,
  output logic [XLEN-1:0] load_data
);

  logic [7:0]      mask;
  logic [XLEN-1:0] data_mask;
  logic [XLEN-1:0] raw;
  logic [5:0]      shamt;

  always_comb begin
    mask  = size_mask(size);
    shamt = {lane, 3'b000};
    for (int b = 0; b < 8; b++) begin
      data_mask[b*8 +: 8] = {8{mask[b]}};
    end
    byte_en       = mask << lane;
    wdata_shifted = (wdata & data_mask) << shamt;
    raw           = word >> shamt;

    // Double accesses fill the register, so they are never extended.
    case (size)
      MASK_BYTE: load_data = is_unsigned ? {56'd0, raw[7:0]}  : {{56{raw[7]}},  raw[7:0]};
      MASK_HALF: load_data = is_unsigned ? {48'd0, raw[15:0]} : {{48{raw[15]}}, raw[15:0]};
      MASK_WORD: load_data = is_unsigned ? {32'd0, raw[31:0]} : {{32{raw[31]}}, raw[31:0]};
      default:   load_data = raw;
    endcase
  end

endmodule

// File: rtl/dmem_ctrl.sv
// Byte-addressed data memory with one-outstanding valid/ready handshake and a
// programmable response latency; stores write at acceptance, loads sample there.
module dmem_ctrl
  import dmem_ctrl_pkg::*;
#(
  parameter int DEPTH_BYTES = 1024,
  parameter int RSP_LATENCY = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic [XLEN-1:0]             req_addr,
  input  logic                        req_wen,
  input  logic [1:0]                  req_size,
  input  logic                        req_unsigned,
  input  logic [XLEN-1:0]             req_wdata,
  output logic                        rsp_valid,
  input  logic                        rsp_ready,
  output logic [XLEN-1:0]             rsp_rdata,
  output logic                        rsp_err,
  output logic [DEPTH_BYTES-1:0][7:0] mem_dump_o
);

  localparam int WORDS = DEPTH_BYTES / 8;
  localparam int AW    = $clog2(DEPTH_BYTES);
  localparam int WI    = (AW > 3) ? AW - 3 : 1;

  logic [WORDS-1:0][XLEN-1:0] mem;
  logic [1:0]      state;
  logic [3:0]      cnt;
  logic [XLEN-1:0] res_data;
  logic            res_err;

  logic            accept;
  logic [WI-1:0]   word_idx;
  logic            misaligned;
  logic            out_of_range;
  logic            err;
  logic [7:0]      byte_en;
  logic [XLEN-1:0] wdata_shifted;
  logic [XLEN-1:0] load_data;

  assign req_ready  = (state == ST_IDLE);
  assign rsp_valid  = (state == ST_RESP);
  assign rsp_rdata  = res_data;
  assign rsp_err    = res_err;
  assign mem_dump_o = mem;

  assign accept   = req_valid && req_ready;
  assign word_idx = WI'(req_addr >> 3);

  always_comb begin
    case (req_size)
      MASK_BYTE: misaligned = 1'b0;
      MASK_HALF: misaligned = req_addr[0];
      MASK_WORD: misaligned = |req_addr[1:0];
      default:   misaligned = |req_addr[2:0];
    endcase
  end

  // Full-width compare: high address bits must never alias into the array.
  assign out_of_range = (req_addr >= XLEN'(DEPTH_BYTES));
  assign err          = misaligned || out_of_range;

  dmem_lane_align u_align (
    .lane          (req_addr[2:0]),
    .size          (req_size),
    .is_unsigned   (req_unsigned),
    .word          (mem[word_idx]),
    .wdata         (req_wdata),
    .byte_en       (byte_en),
    .wdata_shifted (wdata_shifted),
    .load_data     (load_data)
  );

  // NOTE: the array has no reset on purpose; contents must survive rst and a
  // reset branch would force flops instead of a RAM.
  always_ff @(posedge clk) begin
    if (accept && req_wen && !err) begin
      for (int b = 0; b < 8; b++) begin
        if (byte_en[b]) mem[word_idx][b*8 +: 8] <= wdata_shifted[b*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      cnt      <= 4'd0;
      res_data <= '0;
      res_err  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            res_err  <= err;
            res_data <= (err || req_wen) ? '0 : load_data;
            cnt      <= 4'(RSP_LATENCY - 1);
            state    <= (RSP_LATENCY == 1) ? ST_RESP : ST_WAIT;
          end
        end
        ST_WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) state <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl: one instance at latency 1 and one at latency 3,
// driven through a shared request bus and selected by sel.
module tb_dmem_ctrl;
  import dmem_ctrl_pkg::*;

  localparam int DEPTH = 1024;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sel = 1'b0;
  logic req_valid = 1'b0, req_wen = 1'b0, req_unsigned = 1'b0, rsp_ready = 1'b0;
  logic [1:0]      req_size = 2'b00;
  logic [XLEN-1:0] req_addr = '0, req_wdata = '0;

  logic req_ready_a, rsp_valid_a, rsp_err_a, req_ready_b, rsp_valid_b, rsp_err_b;
  logic [XLEN-1:0] rsp_rdata_a, rsp_rdata_b;
  logic [DEPTH-1:0][7:0] dump_a, dump_b;

  logic req_ready, rsp_valid, rsp_err;
  logic [XLEN-1:0] rsp_rdata;
  logic [DEPTH-1:0][7:0] dump, snap;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  dmem_ctrl #(.DEPTH_BYTES(DEPTH), .RSP_LATENCY(1)) dut_a (
    .clk(clk), .rst(rst), .req_valid(req_valid && !sel), .req_ready(req_ready_a),
    .req_addr(req_addr), .req_wen(req_wen), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_wdata(req_wdata), .rsp_valid(rsp_valid_a),
    .rsp_ready(rsp_ready && !sel), .rsp_rdata(rsp_rdata_a), .rsp_err(rsp_err_a),
    .mem_dump_o(dump_a)
  );

  dmem_ctrl #(.DEPTH_BYTES(DEPTH), .RSP_LATENCY(3)) dut_b (
    .clk(clk), .rst(rst), .req_valid(req_valid && sel), .req_ready(req_ready_b),
    .req_addr(req_addr), .req_wen(req_wen), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_wdata(req_wdata), .rsp_valid(rsp_valid_b),
    .rsp_ready(rsp_ready && sel), .rsp_rdata(rsp_rdata_b), .rsp_err(rsp_err_b),
    .mem_dump_o(dump_b)
  );

  assign req_ready = sel ? req_ready_b : req_ready_a;
  assign rsp_valid = sel ? rsp_valid_b : rsp_valid_a;
  assign rsp_err   = sel ? rsp_err_b   : rsp_err_a;
  assign rsp_rdata = sel ? rsp_rdata_b : rsp_rdata_a;
  assign dump      = sel ? dump_b      : dump_a;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%016h expected 0x%016h", name, act, exp);
  endtask

  // Full transaction: present, accept, wait for response, check, retire.
  task automatic do_req(input string name, input logic wen, input logic [1:0] size,
                        input logic uns, input logic [63:0] addr, input logic [63:0] wdata,
                        input logic [63:0] exp_data, input logic exp_err, input int exp_lat);
    int lat;
    check({name, " ready_before"}, 64'(req_ready), 64'd1);
    req_valid = 1'b1; req_wen = wen; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check({name, " rsp_valid"}, 64'(rsp_valid), 64'd1);
    check({name, " latency"}, 64'(lat), 64'(exp_lat));
    check({name, " rdata"}, rsp_rdata, exp_data);
    check({name, " err"}, 64'(rsp_err), 64'(exp_err));
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    check({name, " ready_after"}, 64'(req_ready), 64'd1);
  endtask

  typedef struct {
    string       name;
    logic        wen;
    logic [1:0]  size;
    logic        uns;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [63:0] exp_data;
    logic        exp_err;
  } vec_t;

  vec_t vecs[17];

  initial begin
    vecs[0]  = '{"st_d_10",    1, MASK_DOUBLE, 0, 64'h10,  64'h1122334455667788, 64'h0, 0};
    vecs[1]  = '{"ld_d_10",    0, MASK_DOUBLE, 0, 64'h10,  64'h0, 64'h1122334455667788, 0};
    vecs[2]  = '{"st_b_13",    1, MASK_BYTE,   0, 64'h13,  64'hFFFF_FF80, 64'h0, 0};
    vecs[3]  = '{"ld_b_13_s",  0, MASK_BYTE,   0, 64'h13,  64'h0, 64'hFFFFFFFFFFFFFF80, 0};
    vecs[4]  = '{"ld_b_13_u",  0, MASK_BYTE,   1, 64'h13,  64'h0, 64'h80, 0};
    vecs[5]  = '{"ld_d_10_b",  0, MASK_DOUBLE, 0, 64'h10,  64'h0, 64'h1122334480667788, 0};
    vecs[6]  = '{"ld_h_12_s",  0, MASK_HALF,   0, 64'h12,  64'h0, 64'hFFFFFFFFFFFF8066, 0};
    vecs[7]  = '{"ld_w_14_u",  0, MASK_WORD,   1, 64'h14,  64'h0, 64'h11223344, 0};
    vecs[8]  = '{"ld_w_10_s",  0, MASK_WORD,   0, 64'h10,  64'h0, 64'hFFFFFFFF80667788, 0};
    vecs[9]  = '{"st_h_16",    1, MASK_HALF,   0, 64'h16,  64'hABCD_1234, 64'h0, 0};
    vecs[10] = '{"ld_d_10_c",  0, MASK_DOUBLE, 0, 64'h10,  64'h0, 64'h1234334480667788, 0};
    vecs[11] = '{"st_d_1f8",   1, MASK_DOUBLE, 0, 64'h1F8, 64'hDEADBEEFCAFEF00D, 64'h0, 0};
    vecs[12] = '{"ld_h_11",    0, MASK_HALF,   0, 64'h11,  64'h0, 64'h0, 1};
    vecs[13] = '{"st_w_1fe",   1, MASK_WORD,   0, 64'h1FE, 64'h12345678, 64'h0, 1};
    vecs[14] = '{"ld_d_1f8",   0, MASK_DOUBLE, 0, 64'h1F8, 64'h0, 64'hDEADBEEFCAFEF00D, 0};
    vecs[15] = '{"st_b_3ff",   1, MASK_BYTE,   0, 64'h3FF, 64'h7F, 64'h0, 0};
    vecs[16] = '{"ld_b_3ff",   0, MASK_BYTE,   0, 64'h3FF, 64'h0, 64'h7F, 0};

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("reset req_ready", 64'(req_ready), 64'd1);
    check("reset rsp_valid", 64'(rsp_valid), 64'd0);
    check("reset rdata",     rsp_rdata,      64'd0);
    check("reset err",       64'(rsp_err),   64'd0);

    for (int i = 0; i < 17; i++) begin
      do_req(vecs[i].name, vecs[i].wen, vecs[i].size, vecs[i].uns, vecs[i].addr,
             vecs[i].wdata, vecs[i].exp_data, vecs[i].exp_err, 1);
    end

    // Out-of-range accesses error and leave the array untouched.
    snap = dump;
    do_req("st_d_400", 1, MASK_DOUBLE, 0, 64'h400, 64'hFFFFFFFFFFFFFFFF, 64'h0, 1, 1);
    check("dump unchanged lo", dump[511:0], snap[511:0]);
    check("dump unchanged hi", 64'(dump != snap), 64'd0);
    do_req("st_b_hiaddr", 1, MASK_BYTE, 0, 64'hFFFF_FFFF_0000_0010, 64'h55, 64'h0, 1, 1);
    check("no alias", 64'(dump != snap), 64'd0);
    do_req("ld_d_400", 0, MASK_DOUBLE, 0, 64'h400, 64'h0, 64'h0, 1, 1);

    // Latency 3 with a stalled consumer; a request offered while busy is ignored.
    sel = 1'b1;
    #1;
    do_req("b_st_d_40", 1, MASK_DOUBLE, 0, 64'h40, 64'h0102030405060708, 64'h0, 0, 3);
    req_valid = 1'b1; req_wen = 1'b0; req_size = MASK_DOUBLE; req_unsigned = 1'b0;
    req_addr = 64'h40;
    @(posedge clk); #1;
    req_wen = 1'b1; req_wdata = 64'hBAD0BAD0BAD0BAD0;
    for (int c = 1; c <= 3; c++) begin
      check($sformatf("b_wait%0d rsp_valid", c), 64'(rsp_valid), 64'(c == 3));
      check($sformatf("b_wait%0d req_ready", c), 64'(req_ready), 64'd0);
      if (c < 3) begin
        @(posedge clk); #1;
      end
    end
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      check($sformatf("b_hold%0d rsp_valid", c), 64'(rsp_valid), 64'd1);
      check($sformatf("b_hold%0d req_ready", c), 64'(req_ready), 64'd0);
      check($sformatf("b_hold%0d rdata", c), rsp_rdata, 64'h0102030405060708);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    check("b_release rsp_valid", 64'(rsp_valid), 64'd0);
    check("b_release req_ready", 64'(req_ready), 64'd1);
    do_req("b_ld_d_40", 0, MASK_DOUBLE, 0, 64'h40, 64'h0, 64'h0102030405060708, 0, 3);

    // Asynchronous reset during WAIT: response dropped, store kept.
    req_valid = 1'b1; req_wen = 1'b1; req_size = MASK_BYTE; req_addr = 64'h20;
    req_wdata = 64'hAA;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("b_inwait req_ready", 64'(req_ready), 64'd0);
    #2 rst = 1'b1;
    #1;
    check("b_rst rsp_valid", 64'(rsp_valid), 64'd0);
    check("b_rst req_ready", 64'(req_ready), 64'd1);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    do_req("b_ld_b_20", 0, MASK_BYTE, 1, 64'h20, 64'h0, 64'hAA, 0, 3);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
